// File: rtl/fp_mul.sv
// fp_mul: parameterised IEEE-754-style binary floating-point multiplier with one output register.
// Define FP_MUL_FTZ_EN to flush subnormal operands and results to signed zero.
module fp_mul #(
  parameter int EXPONENT_WIDTH = 5,
  parameter int MANTISSA_WIDTH = 10
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic [EXPONENT_WIDTH+MANTISSA_WIDTH:0] flp_a,
  input  logic [EXPONENT_WIDTH+MANTISSA_WIDTH:0] flp_b,
  output logic                                   sign,
  output logic [EXPONENT_WIDTH-1:0]              exponent,
  output logic [MANTISSA_WIDTH-1:0]              prod
);

  localparam int E   = EXPONENT_WIDTH;
  localparam int M   = MANTISSA_WIDTH;
  localparam int PW  = 2*M + 2;
  localparam int XW  = E + 8;
  localparam int LZW = $clog2(PW + 1);

  localparam logic signed [XW-1:0] BIAS_X = XW'((1 << (E-1)) - 1);
  localparam logic signed [XW-1:0] EMAX_X = XW'((1 << E) - 1);
  localparam logic signed [XW-1:0] ONE_X  = XW'(1);
  localparam logic signed [XW-1:0] ZERO_X = XW'(0);
`ifndef FP_MUL_FTZ_EN
  localparam logic signed [XW-1:0] PW_X   = XW'(PW);
`endif

  // Subnormal operands (exponent field 0) behave as exponent 1.
  function automatic logic signed [XW-1:0] eff_exp(input logic [E-1:0] e);
    if (e == {E{1'b0}}) begin
      eff_exp = ONE_X;
    end else begin
      eff_exp = $signed({{(XW-E){1'b0}}, e});
    end
  endfunction

  logic                 w_sa, w_sb;
  logic [E-1:0]         w_ea, w_eb;
  logic [M-1:0]         w_fa, w_fb;
  logic                 w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_a_zero, w_b_zero;
  logic [M:0]           w_ma, w_mb;
  logic [PW-1:0]        w_p;
  logic signed [XW-1:0] w_eab;

  assign {w_sa, w_ea, w_fa} = flp_a;
  assign {w_sb, w_eb, w_fb} = flp_b;

  assign w_a_nan = (&w_ea) & (|w_fa);
  assign w_b_nan = (&w_eb) & (|w_fb);
  assign w_a_inf = (&w_ea) & ~(|w_fa);
  assign w_b_inf = (&w_eb) & ~(|w_fb);
`ifdef FP_MUL_FTZ_EN
  assign w_a_zero = ~(|w_ea);
  assign w_b_zero = ~(|w_eb);
`else
  assign w_a_zero = ~(|w_ea) & ~(|w_fa);
  assign w_b_zero = ~(|w_eb) & ~(|w_fb);
`endif

  assign w_ma  = {|w_ea, w_fa};
  assign w_mb  = {|w_eb, w_fb};
  assign w_p   = {{(M+1){1'b0}}, w_ma} * {{(M+1){1'b0}}, w_mb};
  assign w_eab = eff_exp(w_ea) + eff_exp(w_eb) - BIAS_X;

  logic [LZW-1:0]       w_lz;
  logic [PW-1:0]        w_pn;
  logic signed [XW-1:0] w_en;
  logic [PW-1:0]        w_pd;
  logic                 w_sticky_sh;
`ifndef FP_MUL_FTZ_EN
  logic signed [XW-1:0] w_sh;
  logic [2*PW-1:0]      w_wide;
`endif
  logic [M-1:0]         w_frac;
  logic                 w_guard, w_sticky;
  logic [M:0]           w_frac_r;
  logic signed [XW-1:0] w_exp_f;

  // Normalise, optionally denormalise, then round to nearest even.
  always_comb begin
    w_lz = {LZW{1'b0}};
`ifdef FP_MUL_FTZ_EN
    if (w_p[PW-1]) begin
      w_lz = {LZW{1'b0}};
    end else begin
      w_lz = LZW'(1);
    end
`else
    for (int i = 0; i < PW; i++) begin
      if (w_p[i]) begin
        w_lz = LZW'(PW - 1 - i);
      end else begin
        w_lz = w_lz;
      end
    end
`endif
    w_pn = w_p << w_lz;
    w_en = w_eab + ONE_X - $signed({{(XW-LZW){1'b0}}, w_lz});
`ifdef FP_MUL_FTZ_EN
    w_pd        = w_pn;
    w_sticky_sh = 1'b0;
`else
    // Bits shifted out while forming a subnormal fold into sticky.
    w_sh   = ONE_X - w_en;
    w_wide = {w_pn, {PW{1'b0}}} >> ((w_sh > PW_X) ? LZW'(PW) : w_sh[LZW-1:0]);
    if (w_en <= ZERO_X) begin
      w_pd        = w_wide[2*PW-1:PW];
      w_sticky_sh = |w_wide[PW-1:0];
    end else begin
      w_pd        = w_pn;
      w_sticky_sh = 1'b0;
    end
`endif
    w_frac   = w_pd[PW-2:M+1];
    w_guard  = w_pd[M];
    w_sticky = (|w_pd[M-1:0]) | w_sticky_sh;
    w_frac_r = {1'b0, w_frac} + {{M{1'b0}}, w_guard & (w_sticky | w_frac[0])};
    // A hidden bit of 0 means subnormal; a rounding carry bumps the exponent (0 -> 1 included).
    w_exp_f  = (w_pd[PW-1] ? w_en : ZERO_X) + $signed({{(XW-1){1'b0}}, w_frac_r[M]});
  end

  logic         w_sign_n;
  logic [E-1:0] w_exp_n;
  logic [M-1:0] w_frac_n;

  // Special-case priority: NaN, infinity, zero, overflow, then the rounded result.
  always_comb begin
    w_sign_n = w_sa ^ w_sb;
    w_exp_n  = {E{1'b0}};
    w_frac_n = {M{1'b0}};
    if (w_a_nan | w_b_nan | (w_a_zero & w_b_inf) | (w_a_inf & w_b_zero)) begin
      w_sign_n = 1'b0;
      w_exp_n  = {E{1'b1}};
      w_frac_n = {1'b1, {(M-1){1'b0}}};
    end else if (w_a_inf | w_b_inf) begin
      w_exp_n  = {E{1'b1}};
    end else if (w_a_zero | w_b_zero) begin
      w_exp_n  = {E{1'b0}};
    end else if (w_exp_f >= EMAX_X) begin
      w_exp_n  = {E{1'b1}};
`ifdef FP_MUL_FTZ_EN
    end else if (w_exp_f <= ZERO_X) begin
      w_exp_n  = {E{1'b0}};
`endif
    end else begin
      w_exp_n  = w_exp_f[E-1:0];
      w_frac_n = w_frac_r[M-1:0];
    end
  end

  logic         r_sign;
  logic [E-1:0] r_exp;
  logic [M-1:0] r_frac;

  // Output register, cleared asynchronously by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sign <= 1'b0;
      r_exp  <= {E{1'b0}};
      r_frac <= {M{1'b0}};
    end else begin
      r_sign <= w_sign_n;
      r_exp  <= w_exp_n;
      r_frac <= w_frac_n;
    end
  end

  assign sign     = r_sign;
  assign exponent = r_exp;
  assign prod     = r_frac;

endmodule

// File: tb/tb_fp_mul.sv
// tb_fp_mul: scoreboard bench for fp_mul at half precision, using a real-arithmetic reference.
module tb_fp_mul;

  logic        clk;
  logic        rst_n;
  logic [15:0] flp_a, flp_b;
  logic        sign;
  logic [4:0]  exponent;
  logic [9:0]  prod;
  logic [15:0] w_out;

  int n_cmp = 0;
  int n_err = 0;
  logic [15:0] exp_q[$];

  fp_mul dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .flp_a    (flp_a),
    .flp_b    (flp_b),
    .sign     (sign),
    .exponent (exponent),
    .prod     (prod)
  );

  assign w_out = {sign, exponent, prod};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    n_cmp++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic real pow2(input int k);
    real r;
    r = 1.0;
    if (k >= 0) begin
      for (int i = 0; i < k; i++) r = r * 2.0;
    end else begin
      for (int i = 0; i < -k; i++) r = r / 2.0;
    end
    return r;
  endfunction

  function automatic real h2r(input logic [15:0] h);
    int e, f;
    e = int'(h[14:10]);
    f = int'(h[9:0]);
    if (e == 0) return f * pow2(-24);
    return (f + 1024) * pow2(e - 25);
  endfunction

  // Independent reference: exact real product rounded to half precision, ties to even.
  function automatic logic [15:0] model_mul(input logic [15:0] a, input logic [15:0] b);
    logic s, an, bn, ai, bi, az, bz;
    real  v, q, fr;
    int   ee, n;
    s  = a[15] ^ b[15];
    an = (a[14:10] == 5'h1F) && (a[9:0] != 10'h000);
    bn = (b[14:10] == 5'h1F) && (b[9:0] != 10'h000);
    ai = (a[14:10] == 5'h1F) && (a[9:0] == 10'h000);
    bi = (b[14:10] == 5'h1F) && (b[9:0] == 10'h000);
    az = (a[14:0] == 15'h0000);
    bz = (b[14:0] == 15'h0000);
    if (an || bn || (az && bi) || (ai && bz)) return 16'h7E00;
    if (ai || bi) return {s, 15'h7C00};
    if (az || bz) return {s, 15'h0000};
    v  = h2r(a) * h2r(b);
    ee = -14;
    for (int k = -14; k <= 40; k++) begin
      if (v >= pow2(k)) ee = k;
    end
    q  = v / pow2(ee - 10);
    n  = $rtoi(q);
    fr = q - n;
    if (fr > 0.5 || (fr == 0.5 && n[0])) n++;
    if (n == 2048) begin
      n  = 1024;
      ee = ee + 1;
    end
    if (ee > 15) return {s, 15'h7C00};
    if (n >= 1024) return {s, 5'(ee + 15), n[9:0]};
    return {s, 5'b00000, n[9:0]};
  endfunction

  task automatic pop_check(input string tag);
    logic [15:0] e;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: got %h expected <empty scoreboard>", tag, w_out);
    end else begin
      e = exp_q.pop_front();
      chk(tag, w_out, e);
    end
  endtask

  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic [15:0] e, input string tag);
    @(negedge clk);
    flp_a = a;
    flp_b = b;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    pop_check(tag);
  endtask

  logic [15:0] dir_a[14] = '{16'h2E66, 16'h211F, 16'h4500, 16'h1419, 16'h0400, 16'h7BFF, 16'hFC00,
                             16'h0000, 16'h7E01, 16'h3C00, 16'h8000, 16'h0001, 16'h7C00, 16'h7C00};
  logic [15:0] dir_b[14] = '{16'h2E66, 16'h211F, 16'hC500, 16'h1419, 16'h0400, 16'h7BFF, 16'h3C00,
                             16'h7C00, 16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00, 16'h7C00, 16'h8000};
  logic [15:0] dir_e[14] = '{16'h211E, 16'h068E, 16'hCE40, 16'h0011, 16'h0000, 16'h7C00, 16'hFC00,
                             16'h7E00, 16'h7E00, 16'h3C00, 16'h8000, 16'h0001, 16'h7C00, 16'h7E00};

  initial begin
    logic [15:0] ra, rb;
    rst_n = 1'b0;
    flp_a = 16'h2E66;
    flp_b = 16'h2E66;
    repeat (2) @(posedge clk);
    #1;
    chk("reset", w_out, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      run_op(dir_a[i], dir_b[i], dir_e[i], $sformatf("dir%0d", i));
    end

    // Back-to-back random pairs, biased towards interesting exponent ranges.
    for (int i = 0; i < 300; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      if (i % 3 == 1) begin
        ra[14:10] = 5'($urandom_range(0, 12));
        rb[14:10] = 5'($urandom_range(0, 12));
      end else if (i % 3 == 2) begin
        ra[14:10] = 5'($urandom_range(20, 30));
        rb[14:10] = 5'($urandom_range(20, 30));
      end else begin
        ra = ra;
      end
      run_op(ra, rb, model_mul(ra, rb), $sformatf("rnd%0d", i));
    end

    // Asynchronous reset between edges while the output holds a product.
    run_op(16'h2E66, 16'h2E66, 16'h211E, "pre_rst");
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst", w_out, 16'h0000);
    flp_a = 16'h4500;
    flp_b = 16'hC500;
    @(posedge clk);
    #1;
    chk("rst_hold", w_out, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back(16'hCE40);
    @(posedge clk);
    #1;
    pop_check("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fp_mul.md
Name:
fp_mul

Overview:
- Parameterised IEEE-754-style binary floating-point multiplier; default is half precision (1 sign, 5 exponent, 10 mantissa bits).
- Multiplies two packed operands and presents the result as separate registered sign, exponent and mantissa fields.
- Used as the multiply stage of the CNN MAC datapath.
- Single clock; one register stage.

Parameters:
- EXPONENT_WIDTH, 5: exponent field width E; bias = 2^(E-1)-1.
- MANTISSA_WIDTH, 10: stored fraction width M (hidden bit excluded).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- flp_a  input  E+M+1  operand A, packed {sign, exponent, fraction}.
- flp_b  input  E+M+1  operand B, same format.
- sign  output  1  result sign.
- exponent  output  E  result biased exponent field.
- prod  output  M  result fraction field.

Behaviour:
- Interface: clock is clk; reset is rst_n, asynchronous and active-low.
- Reset: while rst_n=0, sign, exponent and prod are 0 immediately, without waiting for a clock edge.
- Latency: combinational datapath followed by one output register.
  - Operands present before rising edge N appear on the outputs after edge N.
  - No handshake; a new operand pair is accepted every cycle.
- Packed result is {sign, exponent, prod}.
- Sign: XOR of the operand signs, for all cases including zero and infinity. Exception: NaN results use sign 0.
- Normal path:
  - Significand = {1, frac}, or {0, frac} for subnormal inputs, which use effective exponent 1.
  - Multiply the two (M+1)-bit significands into a 2M+2-bit product.
  - Exponent = ea + eb - bias.
  - If the product is ≥ 2.0, shift right by 1 and increment the exponent.
  - If a subnormal input leaves leading zeros, normalise left and decrement the exponent.
- Rounding: round-to-nearest, ties-to-even, using guard/round/sticky taken from the discarded product bits.
  - If rounding carries out of the mantissa, renormalise and increment the exponent.
- Underflow:
  - If the result exponent is ≤ 0, shift the significand right by (1 - exp) to form a subnormal; shifted-out bits accumulate into sticky.
  - Then round; output exponent field is 0.
  - If rounding lands at 2^(1-bias), emit exponent=1, prod=0.
  - Total underflow gives signed zero.
- Overflow: if the final exponent is ≥ 2^E-1, output signed infinity (exponent all ones, prod=0).
- Special operands:
  - Any NaN input, or 0 × ∞: canonical NaN, i.e. sign 0, exponent all ones, prod MSB=1, rest 0.
  - ∞ × non-zero finite: signed ∞.
  - Zero × finite: signed zero.
- Reset mid-operation: any in-flight result is discarded. The first output after rst_n is released reflects operands sampled at the first subsequent rising edge.

Optional Feature:
- Macro: FP_MUL_FTZ_EN.
- When defined:
  - Subnormal inputs are treated as signed zero.
  - Any result that would be subnormal (exp ≤ 0 after rounding) is flushed to signed zero.
  - The subnormal shifter and the left-normaliser are omitted.
- When undefined: full gradual-underflow behaviour as described in Behaviour (default).

Test Plan:
- Regression runs with FP_MUL_FTZ_EN undefined.
- 0x2E66 × 0x2E66 (≈0.1²) -> {sign,exponent,prod} = 0x211E after one clock.
- 0x211F × 0x211F (≈0.01²) -> 0x068E; 0x4500 × 0xC500 (5 × -5) -> 0xCE40 (-25).
- 0x1419 × 0x1419 -> subnormal 0x0011; 0x0400 × 0x0400 -> 0x0000 (full underflow).
- 0x7BFF × 0x7BFF -> 0x7C00 (overflow to +∞); 0xFC00 × 0x3C00 -> 0xFC00; 0x0000 × 0x7C00 -> 0x7E00; 0x7E01 × 0x3C00 -> 0x7E00.
- Back-to-back operands on consecutive cycles -> each result appears exactly one edge later; no bubbles.
- Drive rst_n low between clock edges while outputs hold 0x211E -> outputs 0 immediately; after release, the next edge loads the current product.
